// File: rtl/alu_addsub_seq.sv
// alu_addsub_seq: multi-cycle add/subtract, one SLICE-bit slice per clock,
// LSB slice first, registered carry between slices. Z/V/N/C flags in signed
// or unsigned mode, start/busy/done handshake.
// Build option: define ALU_SATURATE_EN to clamp the result on overflow
// instead of wrapping. Without it the result always wraps.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the start edge
// RUN   | one slice added per clock; last slice publishes result and done
module alu_addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ctrl,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             C
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;
  logic load, step, fin, last;

  logic [WIDTH-1:0] a_q, b_q;
  logic             ctrl_q, sign_q, carry_q;
  logic [CW-1:0]    cnt_q;

  logic [SLICE-1:0] a_s, b_s;
  logic [SLICE:0]   sum_s;
  logic [WIDTH-1:0] acc_nx, res_fin;
  logic             cout, cin_msb, v_fin, n_fin;

  // slice adder; B slice inverted for subtract, initial carry supplies the +1
  assign a_s     = a_q[SLICE-1:0];
  assign b_s     = b_q[SLICE-1:0] ^ {SLICE{ctrl_q}};
  assign sum_s   = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
  assign cout    = sum_s[SLICE];
  assign cin_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ sum_s[SLICE-1];
  assign last    = (cnt_q == '0);
  assign busy    = (state == RUN);

  // flags only matter on the last slice, where a_s/b_s/sum_s hold the MSB slice
  assign v_fin = sign_q ? (cin_msb ^ cout) : (ctrl_q ? ~cout : cout);
  assign n_fin = sign_q ? sum_s[SLICE-1] : (ctrl_q & ~cout);

  generate
    if (NSLICE > 1) begin : g_acc
      logic [WIDTH-SLICE-1:0] acc_q;
      assign acc_nx = {sum_s[SLICE-1:0], acc_q};
      // finished slices shift in from the top so slice 0 ends up at the bottom
      always_ff @(posedge clk or posedge reset) begin
        if (reset)     acc_q <= '0;
        else if (load) acc_q <= '0;
        else if (step) acc_q <= acc_nx[WIDTH-1:SLICE];
      end
    end else begin : g_acc1
      assign acc_nx = sum_s[SLICE-1:0];
    end
  endgenerate

`ifdef ALU_SATURATE_EN
  // clamp on overflow; the MSB slice of A is still in a_s on the last step
  always_comb begin
    res_fin = acc_nx;
    if (v_fin) begin
      if (sign_q)
        res_fin = a_s[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else if (ctrl_q)
        res_fin = '0;
      else
        res_fin = '1;
    end
  end
`else
  assign res_fin = acc_nx;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and datapath strobes
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          fin      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, per-slice shift, slice down-counter and output publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 1'b0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
      result  <= '0;
      Z       <= 1'b0;
      V       <= 1'b0;
      N       <= 1'b0;
      C       <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        a_q     <= A;
        b_q     <= B;
        ctrl_q  <= ctrl;
        sign_q  <= Sign;
        carry_q <= ctrl;
        cnt_q   <= CW'(NSLICE - 1);
      end else if (step) begin
        a_q     <= a_q >> SLICE;
        b_q     <= b_q >> SLICE;
        carry_q <= cout;
        cnt_q   <= cnt_q - CW'(1);
      end
      if (fin) begin
        result <= res_fin;
        Z      <= (res_fin == '0);
        V      <= v_fin;
        N      <= n_fin;
        C      <= cout;
      end
    end
  end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Directed bench for alu_addsub_seq: 32/8 main instance, 64/16 wide
// instance and an 8/8 single-slice instance. Expectations follow the
// ALU_SATURATE_EN setting of the build.
module tb_alu_addsub_seq;

`ifdef ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk, reset;

  logic        start, ctrl, sgn, busy, done, z, v, n, c;
  logic [31:0] a, b, res;

  logic        start64, ctrl64, sgn64, busy64, done64, z64, v64, n64, c64;
  logic [63:0] a64, b64, res64;

  logic        start8, ctrl8, sgn8, busy8, done8, z8, v8, n8, c8;
  logic [7:0]  a8, b8, res8;

  int total = 0;
  int bad = 0;

  alu_addsub_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .ctrl(ctrl), .Sign(sgn),
    .busy(busy), .done(done), .result(res), .Z(z), .V(v), .N(n), .C(c));

  alu_addsub_seq #(.WIDTH(64), .SLICE(16)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .A(a64), .B(b64), .ctrl(ctrl64), .Sign(sgn64),
    .busy(busy64), .done(done64), .result(res64), .Z(z64), .V(v64), .N(n64), .C(c64));

  alu_addsub_seq #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .ctrl(ctrl8), .Sign(sgn8),
    .busy(busy8), .done(done8), .result(res8), .Z(z8), .V(v8), .N(n8), .C(c8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // start one 32-bit op, scramble inputs after capture, wait for done (bounded)
  task automatic run32(input logic [31:0] ia, input logic [31:0] ib,
                       input logic ic, input logic is, output int lat);
    a = ia; b = ib; ctrl = ic; sgn = is; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; ctrl = ~ic; sgn = ~is;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({busy, done, res, z, v, n, c} !== 38'd0) begin
      bad++; $display("FAIL reset32: got %h want 0", {busy, done, res, z, v, n, c});
    end
    total++;
    if ({busy64, done64, res64, z64, v64, n64, c64} !== 70'd0) begin
      bad++; $display("FAIL reset64: got %h want 0", {busy64, done64, res64, z64, v64, n64, c64});
    end
    total++;
    if ({busy8, done8, res8, z8, v8, n8, c8} !== 14'd0) begin
      bad++; $display("FAIL reset8: got %h want 0", {busy8, done8, res8, z8, v8, n8, c8});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_signed_overflow;
    int lat;
    logic [31:0] exp_r;
    exp_r = SAT ? 32'h7FFFFFFF : 32'h80000000;
    run32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL sovf_latency: got %0d want 4", lat); end
    total++;
    if (res !== exp_r) begin bad++; $display("FAIL sovf_result: got %h want %h", res, exp_r); end
    total++;
    if ({z, v, n, c, busy} !== 5'b01100) begin
      bad++; $display("FAIL sovf_flags: got zvnc_busy=%b want 01100", {z, v, n, c, busy});
    end
    tick();
    total++;
    if ({done, res} !== {1'b0, exp_r}) begin
      bad++; $display("FAIL sovf_hold: got done=%b res=%h want done=0 res=%h", done, res, exp_r);
    end
  endtask

  task automatic test_unsigned_sub;
    int lat;
    run32(32'd5, 32'd7, 1'b1, 1'b0, lat);
    total++;
    if ({res, z, v, n, c} !== {(SAT ? 32'h0 : 32'hFFFFFFFE), SAT, 3'b110}) begin
      bad++; $display("FAIL usub: got res=%h zvnc=%b want res=%h zvnc=%b%b",
                      res, {z, v, n, c}, (SAT ? 32'h0 : 32'hFFFFFFFE), SAT, 3'b110);
    end
    run32(32'd5, 32'd7, 1'b1, 1'b1, lat);
    total++;
    if ({res, z, v, n, c} !== {32'hFFFFFFFE, 4'b0010}) begin
      bad++; $display("FAIL ssub: got res=%h zvnc=%b want res=fffffffe zvnc=0010", res, {z, v, n, c});
    end
  endtask

  task automatic test_carry_zero;
    int lat;
    run32(32'h12345678, 32'h12345678, 1'b1, 1'b0, lat);
    total++;
    if ({res, z, v, n, c} !== {32'h0, 4'b1001}) begin
      bad++; $display("FAIL zero_sub: got res=%h zvnc=%b want res=0 zvnc=1001", res, {z, v, n, c});
    end
    run32(32'h00FFFFFF, 32'h1, 1'b0, 1'b0, lat);
    total++;
    if ({res, z, v, n, c} !== {32'h01000000, 4'b0000}) begin
      bad++; $display("FAIL carry_prop: got res=%h zvnc=%b want res=01000000 zvnc=0000", res, {z, v, n, c});
    end
    run32(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, lat);
    total++;
    if ({res, z, v, n, c} !== {(SAT ? 32'hFFFFFFFF : 32'h0), ~SAT, 3'b101}) begin
      bad++; $display("FAIL uadd_wrap: got res=%h zvnc=%b want res=%h zvnc=%b%b",
                      res, {z, v, n, c}, (SAT ? 32'hFFFFFFFF : 32'h0), ~SAT, 3'b101);
    end
    run32(32'h80000000, 32'h1, 1'b1, 1'b1, lat);
    total++;
    if ({res, z, v, n, c} !== {(SAT ? 32'h80000000 : 32'h7FFFFFFF), 4'b0101}) begin
      bad++; $display("FAIL ssub_ovf: got res=%h zvnc=%b want res=%h zvnc=0101",
                      res, {z, v, n, c}, (SAT ? 32'h80000000 : 32'h7FFFFFFF));
    end
  endtask

  task automatic test_busy_ignore;
    int dones, first;
    a = 32'd1; b = 32'd2; ctrl = 1'b0; sgn = 1'b0; start = 1'b1;
    tick();
    a = 32'd100; b = 32'd200;
    dones = 0; first = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i >= 2 && i <= 4);
      tick();
      if (i == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_run: got %b want 1", busy); end
      end
      if (done) begin
        dones++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    total++;
    if ({dones, first} !== {32'd1, 32'd4}) begin
      bad++; $display("FAIL busy_ignore: got dones=%0d at=%0d want dones=1 at=4", dones, first);
    end
    total++;
    if (res !== 32'd3) begin bad++; $display("FAIL busy_ignore_res: got %h want 3", res); end
  endtask

  task automatic test_back_to_back;
    int lat, lat2;
    a = 32'd1; b = 32'd2; ctrl = 1'b0; sgn = 1'b0; start = 1'b1;
    tick();
    lat = 0;
    while (!done && lat < 20) begin tick(); lat++; end
    total++;
    if ({lat, res} !== {32'd4, 32'd3}) begin
      bad++; $display("FAIL b2b_first: got lat=%0d res=%h want lat=4 res=3", lat, res);
    end
    a = 32'd10; b = 32'd20;
    tick();
    start = 1'b0;
    lat2 = 0;
    while (!done && lat2 < 20) begin tick(); lat2++; end
    total++;
    if ({lat2, res} !== {32'd4, 32'd30}) begin
      bad++; $display("FAIL b2b_second: got lat=%0d res=%h want lat=4 res=1e", lat2, res);
    end
  endtask

  task automatic test_reset_mid;
    int lat, dones;
    a = 32'd3; b = 32'd4; ctrl = 1'b0; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, res, z, v, n, c} !== 38'd0) begin
      bad++; $display("FAIL reset_mid: got %h want 0", {busy, done, res, z, v, n, c});
    end
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_no_done: got %0d dones want 0", dones); end
    run32(32'd3, 32'd4, 1'b0, 1'b0, lat);
    total++;
    if ({lat, res} !== {32'd4, 32'd7}) begin
      bad++; $display("FAIL reset_recover: got lat=%0d res=%h want lat=4 res=7", lat, res);
    end
  endtask

  task automatic test_nslice1;
    int lat;
    a8 = 8'h30; b8 = 8'h10; ctrl8 = 1'b1; sgn8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'hAA;
    lat = 0;
    while (!done8 && lat < 20) begin tick(); lat++; end
    total++;
    if ({lat, res8, z8, v8, n8, c8} !== {32'd1, 8'h20, 4'b0001}) begin
      bad++; $display("FAIL n1_sub: got lat=%0d res=%h zvnc=%b want lat=1 res=20 zvnc=0001",
                      lat, res8, {z8, v8, n8, c8});
    end
    a8 = 8'h7F; b8 = 8'h01; ctrl8 = 1'b0; sgn8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin tick(); lat++; end
    total++;
    if ({lat, res8, z8, v8, n8, c8} !== {32'd1, (SAT ? 8'h7F : 8'h80), 4'b0110}) begin
      bad++; $display("FAIL n1_sovf: got lat=%0d res=%h zvnc=%b want lat=1 res=%h zvnc=0110",
                      lat, res8, {z8, v8, n8, c8}, (SAT ? 8'h7F : 8'h80));
    end
  endtask

  task automatic test_wide64;
    int lat;
    a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1; ctrl64 = 1'b0; sgn64 = 1'b1; start64 = 1'b1;
    tick();
    start64 = 1'b0; a64 = '0; b64 = '0;
    lat = 0;
    while (!done64 && lat < 20) begin tick(); lat++; end
    total++;
    if ({lat, res64, z64, v64, n64, c64} !==
        {32'd4, (SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000), 4'b0110}) begin
      bad++; $display("FAIL w64_sovf: got lat=%0d res=%h zvnc=%b want lat=4 res=%h zvnc=0110",
                      lat, res64, {z64, v64, n64, c64},
                      (SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000));
    end
    a64 = 64'h0; b64 = 64'h1; ctrl64 = 1'b1; sgn64 = 1'b1; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    lat = 0;
    while (!done64 && lat < 20) begin tick(); lat++; end
    total++;
    if ({lat, res64, z64, v64, n64, c64} !== {32'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010}) begin
      bad++; $display("FAIL w64_sub: got lat=%0d res=%h zvnc=%b want lat=4 res=ffffffffffffffff zvnc=0010",
                      lat, res64, {z64, v64, n64, c64});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; a = '0; b = '0; ctrl = 1'b0; sgn = 1'b0;
    start64 = 1'b0; a64 = '0; b64 = '0; ctrl64 = 1'b0; sgn64 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; ctrl8 = 1'b0; sgn8 = 1'b0;
    test_reset();
    test_signed_overflow();
    test_unsigned_sub();
    test_carry_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_nslice1();
    test_wide64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
